cell_grid_sequencer: RTL and testbench

- Sequential controller that wraps the combinational grid next-state logic.
- Loads an initial pattern row by row over a valid/ready stream, then advances the grid a commanded number of generations (one generation per clock), then streams the final grid back out row by row.
- Sits between the host/UART-side interface and the cell grid. Provides the state register, generation counting, and the read-back path.

---
 rtl/cell_grid_pkg.sv | 19 +
 rtl/cell_grid_increment.sv | 48 ++++
 rtl/cell_grid_sequencer.sv | 126 ++++++++++++
 tb/tb_cell_grid_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cell_grid_pkg.sv
// rtl/cell_grid_pkg.sv - shared types and helpers for the cell grid sequencer
package cell_grid_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DUMP = 2'd3
    } seq_state_t;

    // Row index width; a single-row grid still needs one bit of index.
    function automatic int row_idx_width(input int grid_height);
        if (grid_height <= 1) begin
            return 1;
        end
        return $clog2(grid_height);
    endfunction

endpackage

// File: rtl/cell_grid_increment.sv
// rtl/cell_grid_increment.sv - combinational one-generation life step with dead border
module cell_grid_increment #(
    parameter int GRID_WIDTH  = 8,
    parameter int GRID_HEIGHT = 8
) (
    input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] input_state,
    output logic [GRID_WIDTH*GRID_HEIGHT-1:0] next_state
);

    localparam int N_CELLS = GRID_WIDTH * GRID_HEIGHT;

    // Cells outside the grid read as dead, so patterns never wrap.
    function automatic logic cell_at(input logic [N_CELLS-1:0] g, input int x, input int y);
        logic [N_CELLS-1:0] sh;
        sh = '0;
        if (x < 0 || x >= GRID_WIDTH || y < 0 || y >= GRID_HEIGHT) begin
            return 1'b0;
        end
        sh = g >> (y * GRID_WIDTH + x);
        return sh[0];
    endfunction

    function automatic logic [3:0] neighbours(input logic [N_CELLS-1:0] g, input int x, input int y);
        logic [3:0] n;
        n = 4'd0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (!(dx == 0 && dy == 0)) begin
                    n = n + {3'b000, cell_at(g, x + dx, y + dy)};
                end
            end
        end
        return n;
    endfunction

    // Birth on exactly three neighbours, survival on two or three.
    always_comb begin
        next_state = '0;
        for (int y = 0; y < GRID_HEIGHT; y++) begin
            for (int x = 0; x < GRID_WIDTH; x++) begin
                next_state[y * GRID_WIDTH + x] =
                    (neighbours(input_state, x, y) == 4'd3) ||
                    (cell_at(input_state, x, y) && (neighbours(input_state, x, y) == 4'd2));
            end
        end
    end

endmodule

// File: rtl/cell_grid_sequencer.sv
// rtl/cell_grid_sequencer.sv - load, evolve and read back a life grid over row streams
module cell_grid_sequencer
    import cell_grid_pkg::*;
#(
    parameter int GRID_WIDTH  = 8,
    parameter int GRID_HEIGHT = 8,
    parameter int GEN_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [GEN_WIDTH-1:0]  cmd_gens,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [GRID_WIDTH-1:0] load_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [GRID_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int                N_CELLS  = GRID_WIDTH * GRID_HEIGHT;
    localparam int                ROW_W    = row_idx_width(GRID_HEIGHT);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(GRID_HEIGHT - 1);

    seq_state_t            state_q;
    seq_state_t            state_d;
    logic [N_CELLS-1:0]    grid_q;
    logic [N_CELLS-1:0]    grid_next;
    logic [ROW_W-1:0]      row_q;
    logic [GEN_WIDTH-1:0]  gen_q;
    logic [GRID_WIDTH-1:0] row_data;
    logic                  at_last_row;

    assign at_last_row = (row_q == LAST_ROW);

    cell_grid_increment #(
        .GRID_WIDTH  (GRID_WIDTH),
        .GRID_HEIGHT (GRID_HEIGHT)
    ) u_increment (
        .input_state (grid_q),
        .next_state  (grid_next)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; RUN leaves on the cycle whose decrement reaches zero.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cmd_valid) state_d = LOAD;
            LOAD: if (load_valid && at_last_row) state_d = (gen_q != '0) ? RUN : DUMP;
            RUN:  if (gen_q == GEN_WIDTH'(1)) state_d = DUMP;
            DUMP: if (out_ready && at_last_row) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grid, row index and generation counter; the grid only changes in LOAD and RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grid_q <= '0;
            row_q  <= '0;
            gen_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        gen_q <= cmd_gens;
                        row_q <= '0;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        for (int r = 0; r < GRID_HEIGHT; r++) begin
                            if (row_q == ROW_W'(r)) begin
                                grid_q[r*GRID_WIDTH +: GRID_WIDTH] <= load_data;
                            end
                        end
                        row_q <= at_last_row ? '0 : row_q + 1'b1;
                    end
                end
                RUN: begin
                    grid_q <= grid_next;
                    gen_q  <= gen_q - 1'b1;
                end
                DUMP: begin
                    if (out_ready) begin
                        row_q <= at_last_row ? '0 : row_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Row select for read-back.
    always_comb begin
        row_data = '0;
        for (int r = 0; r < GRID_HEIGHT; r++) begin
            if (row_q == ROW_W'(r)) begin
                row_data = grid_q[r*GRID_WIDTH +: GRID_WIDTH];
            end
        end
    end

    // Outputs depend only on state and row index, never on the matching valid.
    always_comb begin
        cmd_ready  = (state_q == IDLE);
        load_ready = (state_q == LOAD);
        out_valid  = (state_q == DUMP);
        out_data   = (state_q == DUMP) ? row_data : '0;
        out_last   = (state_q == DUMP) && at_last_row;
        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_cell_grid_sequencer.sv
// tb/tb_cell_grid_sequencer.sv - directed bench for cell_grid_sequencer
module tb_cell_grid_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_gens;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Row r of a pattern is byte r (row 0 in the low byte).
    localparam logic [63:0] BLINK   = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLINK1  = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] GLIDER  = 64'h0E02_0400_0000_0000;
    localparam logic [63:0] GLIDER4 = 64'h0606_0000_0000_0000;

    cell_grid_sequencer #(
        .GRID_WIDTH  (8),
        .GRID_HEIGHT (8),
        .GEN_WIDTH   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_gens   (cmd_gens),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [15:0] gens);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_gens  = gens;
        chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk);
    endtask

    task automatic load_rows(input logic [63:0] pat, input int nrows, input bit rnd);
        int  r = 0;
        int  guard = 0;
        bit  lv;
        bit  xfer;
        while (r < nrows && guard < 500) begin
            @(negedge clk);
            lv         = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            load_valid = lv;
            load_data  = pat[8*r +: 8];
            cmd_valid  = rnd ? ($urandom_range(0, 1) != 0) : 1'b0;
            cmd_gens   = rnd ? 16'hFFFF : cmd_gens;
            xfer       = lv && load_ready;
            @(posedge clk);
            if (xfer) r++;
            guard++;
        end
        chk("load_rows_done", 64'(r), 64'(nrows));
    endtask

    task automatic run_count(input string tag, input int gens);
        int n = 0;
        int guard = 0;
        @(negedge clk);
        load_valid = 1'b0;
        cmd_valid  = 1'b1;
        cmd_gens   = 16'h0003;
        out_ready  = 1'b1;
        while (busy && !load_ready && !out_valid && guard < 5000) begin
            n++;
            guard++;
            @(negedge clk);
        end
        chk({tag, "_run_cycles"}, 64'(n), 64'(gens));
    endtask

    task automatic dump_check(input string tag, input logic [63:0] exp, input int stall_row);
        int r = 0;
        int guard = 0;
        int stalls = 0;
        cmd_valid = 1'b0;
        while (r < 8 && guard < 200) begin
            if (r == stall_row && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
                chk({tag, "_stall_valid"}, {63'd0, out_valid}, 64'd1);
                chk({tag, "_stall_data"}, {56'd0, out_data}, {56'd0, exp[8*r +: 8]});
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    chk({tag, "_row_data"}, {56'd0, out_data}, {56'd0, exp[8*r +: 8]});
                    chk({tag, "_row_last"}, {63'd0, out_last}, {63'd0, (r == 7)});
                    r++;
                end
            end
            guard++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk({tag, "_rows_out"}, 64'(r), 64'd8);
        chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        chk({tag, "_cmd_ready_after"}, {63'd0, cmd_ready}, 64'd1);
    endtask

    task automatic run_case(input string tag, input logic [63:0] pat, input logic [15:0] gens,
                            input logic [63:0] exp, input int stall_row, input bit rnd);
        send_cmd(gens);
        load_rows(pat, 8, rnd);
        run_count(tag, int'(gens));
        dump_check(tag, exp, stall_row);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
        chk({tag, "_load_ready"}, {63'd0, load_ready}, 64'd0);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_out_data"}, {56'd0, out_data}, 64'd0);
        chk({tag, "_out_last"}, {63'd0, out_last}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_gens   = '0;
        load_valid = 1'b0;
        load_data  = '0;
        out_ready  = 1'b0;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        run_case("blinker1", BLINK, 16'd1, BLINK1, -1, 1'b0);
        run_case("blinker2", BLINK, 16'd2, BLINK, -1, 1'b0);
        run_case("block5", BLOCK, 16'd5, BLOCK, -1, 1'b0);
        run_case("block0", BLOCK, 16'd0, BLOCK, -1, 1'b0);
        run_case("backpressure", BLINK, 16'd2, BLINK, 2, 1'b1);
        run_case("glider4", GLIDER, 16'd4, GLIDER4, -1, 1'b0);

        send_cmd(16'd0);
        load_rows(BLINK, 3, 1'b0);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        rst        = 1'b1;
        #1;
        check_idle_outputs("rst_load");
        @(negedge clk);
        rst        = 1'b0;
        load_valid = 1'b0;
        run_case("zero_after_rst", 64'd0, 16'd0, 64'd0, -1, 1'b0);

        send_cmd(16'd1000);
        load_rows(BLINK, 8, 1'b0);
        @(negedge clk);
        load_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_run_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_run");
        @(negedge clk);
        rst = 1'b0;
        run_case("blinker_after_rst", BLINK, 16'd1, BLINK1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
